// File: rtl/vga_window_scanner_pkg.sv
// Shared VGA timing defaults, per-pixel flag bundle and a range helper
// used by the window scanner.
package vga_window_scanner_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Sync flags are stored as "pulse on" so a cleared delay line reads as idle.
    typedef struct packed {
        logic active;
        logic inwin;
        logic hs_on;
        logic vs_on;
    } vid_flags_t;

    function automatic logic in_range(input logic [10:0] pos,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi_excl);
        return (pos >= lo) && (pos < hi_excl);
    endfunction

endpackage

// File: rtl/vga_window_scanner_if.sv
// Video/framebuffer signal bundle of the window scanner; master drives the
// window setup and pixel data, slave produces raster, address and colour.
interface vga_window_scanner_if #(
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 16
);
    logic [9:0]         iWinX0;
    logic [9:0]         iWinY0;
    logic [COLOR_W-1:0] iBorderColor;
    logic [COLOR_W-1:0] iPixelData;
    logic [ADDR_W-1:0]  oReadAddress;
    logic [COLOR_W-1:0] oRGB;
    logic               oHsync;
    logic               oVsync;
    logic [9:0]         oHcounter;
    logic [9:0]         oVcounter;
    logic               oFrameStart;

    modport master (
        output iWinX0, iWinY0, iBorderColor, iPixelData,
        input  oReadAddress, oRGB, oHsync, oVsync, oHcounter, oVcounter, oFrameStart
    );

    modport slave (
        input  iWinX0, iWinY0, iBorderColor, iPixelData,
        output oReadAddress, oRGB, oHsync, oVsync, oHcounter, oVcounter, oFrameStart
    );
endinterface

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register; dout is din from DEPTH enabled cycles ago.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/vga_window_scanner.sv
// VGA raster generator that fetches a 2^W x 2^H framebuffer window at a
// per-frame origin and borders the rest of the active area.
module vga_window_scanner
    import vga_window_scanner_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int CLK_DIV     = 2,
    parameter int WIN_W_LOG2  = 8,
    parameter int WIN_H_LOG2  = 8,
    parameter int MEM_LATENCY = 1,
    parameter int COLOR_W     = 3
) (
    input logic Clock,
    input logic Reset,
    vga_window_scanner_if.slave bus
);
    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int ADDR_W = WIN_W_LOG2 + WIN_H_LOG2;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]      div;
    logic                  tick, h_last, v_last, wrap;
    logic [9:0]            hcount, vcount, x0, y0;
    logic [10:0]           hpos, vpos, x_lo, y_lo;
    logic [WIN_W_LOG2-1:0] col;
    logic [WIN_H_LOG2-1:0] row;
    vid_flags_t            flags, flags_d;
    logic [ADDR_W-1:0]     read_addr;
    logic [COLOR_W-1:0]    rgb;
    logic                  hsync, vsync, frame_start;

    assign tick   = (div == DIV_W'(CLK_DIV - 1));
    assign h_last = (hcount == 10'(HT - 1));
    assign v_last = (vcount == 10'(VT - 1));
    assign wrap   = tick && h_last && v_last;

    // 11-bit compare so a window hanging off the screen clips instead of wrapping
    assign hpos = {1'b0, hcount};
    assign vpos = {1'b0, vcount};
    assign x_lo = {1'b0, x0};
    assign y_lo = {1'b0, y0};

    assign flags.active = (hpos < 11'(H_ACTIVE)) && (vpos < 11'(V_ACTIVE));
    assign flags.inwin  = flags.active
                       && in_range(hpos, x_lo, x_lo + 11'(1 << WIN_W_LOG2))
                       && in_range(vpos, y_lo, y_lo + 11'(1 << WIN_H_LOG2));
    assign flags.hs_on  = in_range(hpos, 11'(H_ACTIVE + H_FP), 11'(H_ACTIVE + H_FP + H_SYNC));
    assign flags.vs_on  = in_range(vpos, 11'(V_ACTIVE + V_FP), 11'(V_ACTIVE + V_FP + V_SYNC));

    assign col = WIN_W_LOG2'(hcount - x0);
    assign row = WIN_H_LOG2'(vcount - y0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            x0          <= '0;
            y0          <= '0;
            read_addr   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            div         <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                hcount    <= h_last ? '0 : hcount + 10'd1;
                if (h_last) vcount <= v_last ? '0 : vcount + 10'd1;
                if (wrap) begin
                    x0 <= bus.iWinX0;
                    y0 <= bus.iWinY0;
                end
                read_addr <= flags.inwin ? {col, row} : '0;
            end
        end
    end

    vga_delay_line #(
        .WIDTH($bits(vid_flags_t)),
        .DEPTH(MEM_LATENCY)
    ) u_dly (
        .clk (Clock),
        .rst (Reset),
        .en  (tick),
        .din (flags),
        .dout(flags_d)
    );

    // Final stage lines colour and syncs up with the returning pixel data
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (tick) begin
            rgb   <= flags_d.inwin  ? bus.iPixelData :
                     flags_d.active ? bus.iBorderColor : '0;
            hsync <= ~flags_d.hs_on;
            vsync <= ~flags_d.vs_on;
        end
    end

    assign bus.oReadAddress = read_addr;
    assign bus.oRGB         = rgb;
    assign bus.oHsync       = hsync;
    assign bus.oVsync       = vsync;
    assign bus.oHcounter    = hcount;
    assign bus.oVcounter    = vcount;
    assign bus.oFrameStart  = frame_start;
endmodule

// File: tb/tb_vga_window_scanner.sv
// Directed bench on a shrunken 56x37 raster with an 8x8 window: DUT a uses
// CLK_DIV=2/latency 1, DUT b uses CLK_DIV=1/latency 3.
module tb_vga_window_scanner;
    logic Clock = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic b_done = 1'b0;
    int   cyc_a = 0, cyc_b = 0, fs_cnt = 0;
    int   n_chk = 0, n_err = 0;
    logic [5:0] m0, m1;

    vga_window_scanner_if #(.COLOR_W(3), .ADDR_W(6)) a_if ();
    vga_window_scanner_if #(.COLOR_W(3), .ADDR_W(6)) b_if ();

    vga_window_scanner #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(2), .WIN_W_LOG2(3), .WIN_H_LOG2(3), .MEM_LATENCY(1), .COLOR_W(3)
    ) dut_a (.Clock(Clock), .Reset(rst_a), .bus(a_if));

    vga_window_scanner #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1), .WIN_W_LOG2(3), .WIN_H_LOG2(3), .MEM_LATENCY(3), .COLOR_W(3)
    ) dut_b (.Clock(Clock), .Reset(rst_b), .bus(b_if));

    always #5 Clock = ~Clock;

    // Memory models: a returns data combinationally, b delays two more ticks.
    assign a_if.iPixelData = a_if.oReadAddress[2:0];
    assign b_if.iPixelData = m1[2:0];
    always @(posedge Clock) begin
        if (rst_b) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= b_if.oReadAddress;
            m1 <= m0;
        end
    end

    always @(posedge Clock) cyc_a <= rst_a ? 0 : cyc_a + 1;
    always @(posedge Clock) cyc_b <= rst_b ? 0 : cyc_b + 1;
    always @(negedge Clock) if (a_if.oFrameStart === 1'b1) fs_cnt <= fs_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tick t of DUT a completes on its 2*(t+1)-th clock after reset release.
    task automatic wait_a(input int t);
        int g = 0;
        while (cyc_a < 2 * (t + 1) && g < 20000) begin
            @(posedge Clock); #1; g++;
        end
        if (cyc_a != 2 * (t + 1)) begin
            n_chk++; n_err++;
            $display("FAIL wait_a t=%0d: cycle %0d expected %0d", t, cyc_a, 2 * (t + 1));
        end
    endtask

    task automatic wait_b(input int t);
        int g = 0;
        while (cyc_b < t + 1 && g < 10000) begin
            @(posedge Clock); #1; g++;
        end
        if (cyc_b != t + 1) begin
            n_chk++; n_err++;
            $display("FAIL wait_b t=%0d: cycle %0d expected %0d", t, cyc_b, t + 1);
        end
    endtask

    initial begin : dut_b_seq
        int lo;
        b_if.iWinX0 = 10'd12;
        b_if.iWinY0 = 10'd8;
        b_if.iBorderColor = 3'b101;
        wait_b(0);
        chk("b_rgb_t0", b_if.oRGB, 0);
        chk("b_hs_t0", b_if.oHsync, 1);
        wait_b(98);   chk("b_rgb_39_1", b_if.oRGB, 5); chk("b_hs_39_1", b_if.oHsync, 1);
        wait_b(99);   chk("b_rgb_40_1", b_if.oRGB, 0);
        wait_b(102);  chk("b_hs_43", b_if.oHsync, 1);
        wait_b(103);  chk("b_hs_44", b_if.oHsync, 0); chk("b_rgb_44", b_if.oRGB, 0);
        wait_b(112);
        lo = 0;
        for (int i = 0; i < 56; i++) begin
            @(posedge Clock); #1;
            if (b_if.oHsync == 1'b0) lo++;
        end
        chk("b_hs_len", lo, 6);
        wait_b(1794); chk("b_vs_31", b_if.oVsync, 1);
        wait_b(1795); chk("b_vs_32", b_if.oVsync, 0);
        wait_b(2071); chk("b_fs_on", b_if.oFrameStart, 1); chk("b_h_wrap", b_if.oHcounter, 0);
        wait_b(2072); chk("b_fs_off", b_if.oFrameStart, 0); chk("b_h_1", b_if.oHcounter, 1);
        wait_b(2532); chk("b_addr_org", b_if.oReadAddress, 0);
        wait_b(2926); chk("b_rgb_11_15", b_if.oRGB, 5);
        wait_b(2931); chk("b_addr_end", b_if.oReadAddress, 63);
        wait_b(2934); chk("b_rgb_19_15", b_if.oRGB, 7);
        wait_b(2935); chk("b_rgb_20_15", b_if.oRGB, 5);
        b_done = 1'b1;
    end

    initial begin : dut_a_seq
        int lo, g;
        a_if.iWinX0 = 10'd12;
        a_if.iWinY0 = 10'd8;
        a_if.iBorderColor = 3'b101;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_h", a_if.oHcounter, 0);
        chk("rst_v", a_if.oVcounter, 0);
        chk("rst_hs", a_if.oHsync, 1);
        chk("rst_vs", a_if.oVsync, 1);
        chk("rst_rgb", a_if.oRGB, 0);
        chk("rst_addr", a_if.oReadAddress, 0);
        chk("rst_fs", a_if.oFrameStart, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        wait_a(0);    chk("h_t0", a_if.oHcounter, 1); chk("v_t0", a_if.oVcounter, 0);
        chk("addr_t0", a_if.oReadAddress, 0);
        wait_a(100);  chk("hs_43", a_if.oHsync, 1);
        wait_a(101);  chk("hs_44", a_if.oHsync, 0);
        wait_a(106);  chk("hs_49", a_if.oHsync, 0);
        wait_a(107);  chk("hs_50", a_if.oHsync, 1);
        wait_a(112);
        lo = 0;
        for (int i = 0; i < 112; i++) begin
            @(posedge Clock); #1;
            if (a_if.oHsync == 1'b0) lo++;
        end
        chk("hs_len_clk", lo, 12);
        // frame 0 keeps the window at the origin regardless of iWinX0/Y0
        wait_a(173);  chk("addr_5_3", a_if.oReadAddress, 43);
        chk("h_174", a_if.oHcounter, 6); chk("v_174", a_if.oVcounter, 3);
        wait_a(174);  chk("rgb_5_3", a_if.oRGB, 3);
        wait_a(177);  chk("rgb_8_3", a_if.oRGB, 5);
        wait_a(1737); chk("vs_31", a_if.oVsync, 1);
        wait_a(1793); chk("vs_32", a_if.oVsync, 0);
        wait_a(1904); chk("vs_33", a_if.oVsync, 0);
        wait_a(1905); chk("vs_34", a_if.oVsync, 1);
        wait_a(2071); chk("fs_on", a_if.oFrameStart, 1);
        chk("h_wrap", a_if.oHcounter, 0); chk("v_wrap", a_if.oVcounter, 0);
        @(posedge Clock); #1;
        chk("fs_off", a_if.oFrameStart, 0); chk("h_hold", a_if.oHcounter, 0);

        wait_a(2393); chk("rgb_hblank", a_if.oRGB, 0);
        wait_a(2532); chk("addr_org", a_if.oReadAddress, 0); chk("rgb_11_8", a_if.oRGB, 5);
        wait_a(2744); a_if.iWinX0 = 10'd36;
        wait_a(2812); chk("addr_midchg", a_if.oReadAddress, 5);
        wait_a(2931); chk("addr_end", a_if.oReadAddress, 63);
        wait_a(2932); chk("addr_out", a_if.oReadAddress, 0); chk("rgb_19_15", a_if.oRGB, 7);
        wait_a(2933); chk("rgb_20_15", a_if.oRGB, 5);
        wait_a(3758); chk("rgb_vblank", a_if.oRGB, 0);

        wait_a(4627); chk("addr_35_8", a_if.oReadAddress, 0);
        wait_a(4628); chk("rgb_35_8", a_if.oRGB, 5);
        wait_a(4631); chk("addr_39_8", a_if.oReadAddress, 24);
        wait_a(4687); chk("addr_39_9", a_if.oReadAddress, 25);
        wait_a(4688); chk("addr_clip", a_if.oReadAddress, 0); chk("rgb_39_9", a_if.oRGB, 1);
        wait_a(4689); chk("rgb_clip", a_if.oRGB, 0);

        wait_a(5574);
        rst_a = 1'b1;
        @(posedge Clock); #1;
        chk("mrst_h", a_if.oHcounter, 0);
        chk("mrst_v", a_if.oVcounter, 0);
        chk("mrst_hs", a_if.oHsync, 1);
        chk("mrst_vs", a_if.oVsync, 1);
        chk("mrst_rgb", a_if.oRGB, 0);
        chk("mrst_addr", a_if.oReadAddress, 0);
        repeat (2) @(posedge Clock);
        #1;
        rst_a = 1'b0;
        wait_a(0);    chk("post_h", a_if.oHcounter, 1); chk("post_v", a_if.oVcounter, 0);
        wait_a(58);   chk("post_addr", a_if.oReadAddress, 17);
        chk("fs_count", fs_cnt, 2);

        g = 0;
        while (!b_done && g < 20000) begin
            @(posedge Clock); g++;
        end
        if (!b_done) begin
            n_chk++; n_err++;
            $display("FAIL b_timeout: b sequence incomplete, required done");
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_window_scanner.md
VGA_WINDOW_SCANNER -- requirements
Module: vga_window_scanner

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- CLK_DIV, 2, Clock cycles per pixel tick (>=1)
- WIN_W_LOG2 / WIN_H_LOG2, 8 / 8, framebuffer window size (256x256)
- MEM_LATENCY, 1, pixel ticks from oReadAddress to valid iPixelData (1..4)
- COLOR_W, 3, RGB width

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset first.
- Clock, in, 1, single clock; reset is synchronous and active-high
- Reset, in, 1, synchronous active-high reset
- iWinX0, in, 10, runtime window column origin
- iWinY0, in, 10, runtime window row origin
- iBorderColor, in, COLOR_W, colour for active pixels outside the window
- iPixelData, in, COLOR_W, framebuffer read data
- oReadAddress, out, WIN_W_LOG2+WIN_H_LOG2, {column, row} framebuffer address
- oRGB, out, COLOR_W, pixel colour
- oHsync / oVsync, out, 1 each, active-low syncs
- oHcounter / oVcounter, out, 10 each, undelayed raster position
- oFrameStart, out, 1, one-Clock pulse at raster (0,0)

Function
REQ-003 Divider counts 0..CLK_DIV-1; pixel tick asserts on the Clock cycle where the divider equals CLK_DIV-1. With CLK_DIV=1, the tick is asserted every cycle.
REQ-004 Counters advance only on a pixel tick. oHcounter wraps 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800). oVcounter increments on the H wrap and wraps 0..VT-1, where VT = 525.
REQ-005 Raw hsync is low iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]). Raw vsync is low iff vcount is in [490,491].
REQ-006 active = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).
REQ-007 inwin = active and hcount in [X0, X0+2^WIN_W_LOG2-1] and vcount in [Y0, Y0+2^WIN_H_LOG2-1]. The arithmetic is 11-bit, so a window extending past the screen edge is clipped and does not wrap.
REQ-008 X0/Y0 are shadow registers loaded from iWinX0/iWinY0 only on the pixel tick that moves the raster to (0,0). Mid-frame input changes have no effect until the next frame.
REQ-009 On each pixel tick, oReadAddress is registered:
- when inwin: {hcount-X0, vcount-Y0}
- otherwise: 0
REQ-010 active, inwin, raw hsync and raw vsync pass through a MEM_LATENCY-deep delay line clocked by the pixel tick. oHsync, oVsync and oRGB therefore emerge aligned with iPixelData.
REQ-011 oRGB is registered on the pixel tick from the delayed flags:
- inwin: iPixelData
- active but not inwin: iBorderColor
- otherwise: 0
REQ-012 oFrameStart is high for exactly one Clock cycle: the cycle after the tick that moves the raster to (0,0). It is not delayed.
REQ-013 All outputs hold their values between pixel ticks.

Reset
REQ-014 When Reset=1 at a Clock edge:
- divider, counters, X0/Y0, delay line, oReadAddress, oRGB and oFrameStart are cleared to 0
- oHsync and oVsync are set to 1
REQ-015 Reset mid-frame takes effect on that edge. On the first tick after release, the raster advances from (0,0) to (1,0), and X0/Y0 stay 0 until the next frame wrap.

Structure
REQ-016 The VGA timing defaults (porches, sync widths, totals) are defined once as constants in the shared Definitions include and referenced by this block.
REQ-017 One sub-module, vga_delay_line, implements the parametrised (WIDTH, DEPTH) tick-enabled shift register used by REQ-010.

Verification
REQ-018 Defaults, run 2 frames: HSYNC low for 192 Clocks per line at hcount 656..751. VSYNC low on lines 490..491. oFrameStart pulses once per 800*525*2 = 840000 Clocks.
REQ-019 iWinX0=192, iWinY0=112, iPixelData = the low bits of the address, i.e. oReadAddress[2:0] looped back through a MEM_LATENCY model. At raster (192,112) the address is 0x0000. At (447,367) the address is 0xFFFF. oRGB equals the returned data MEM_LATENCY ticks later.
REQ-020 iBorderColor=3'b101: active pixels outside the window show 101. Pixels at hcount>=640 or vcount>=480 show 000.
REQ-021 Change iWinX0 from 192 to 400 at line 200: the current frame is unchanged. In the next frame the window spans columns 400..639, clipped, and the address column at hcount 639 is 239.
REQ-022 Assert Reset for 3 Clocks at raster (300,250): oHsync=1, oVsync=1, oRGB=0 and counters=0 during reset. Normal timing resumes from (0,0) afterwards.
REQ-023 Repeat REQ-018 and REQ-019 with CLK_DIV=1 and MEM_LATENCY=3: sync positions are unchanged in pixel ticks, and RGB/sync alignment holds.
